dot_accum: RTL and testbench
============================

// Module: dot_accum
// PURPOSE
//  Downstream consumer of the two-lane multiply-add stage (C = A1*B1 + A2*B2, fixed 2-cycle latency, no valid).
//  Re-aligns the operand-side valid through a LAT-deep delay line to the arriving partial sums.
//  Accumulates COUNT partial sums into one dot-product result.
//  Presents the result on a valid/ready output; the upstream stage cannot stall, so overrun is flagged, never back-pressured.
// PARAMETERS
//  WIDTH  32  width of partial sum psum (matches multiply-add output C)
//  ACC_W  40  accumulator/result width; must be >= WIDTH
//  COUNT  8   partial sums per result; legal range 1..65535
//  LAT    2   cycles from op_valid to matching psum; must be >= 1
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  op_valid   in   1      high in the cycle operands are presented to the multiply-add stage
//  psum       in   WIDTH  multiply-add output C, unsigned
//  res_data   out  ACC_W  completed dot product, unsigned
//  res_valid  out  1      res_data holds an unconsumed result
//  res_ready  in   1      consumer accepts res_data when res_valid && res_ready at a rising edge
//  ovr        out  1      sticky: a completed result was dropped
//  term_cnt   out  16     partial sums absorbed into the current accumulation, 0..COUNT-1
// BEHAVIOUR
//  Reset (async, all regs): vld_dly=0, acc=0, term_cnt=0, res_data=0, res_valid=0, ovr=0.
//  Delay line: vld_dly[0]<=op_valid; vld_dly[k]<=vld_dly[k-1]; pv = vld_dly[LAT-1].
//   -> pv is high exactly LAT cycles after op_valid, in the cycle psum holds the matching sum.
//  Width rule: psum is zero-extended to ACC_W; nxt = acc + psum_ext, mod 2^ACC_W (see SAT_EN).
//  pv=0: acc and term_cnt hold.
//  pv=1, term_cnt<COUNT-1: acc<=nxt; term_cnt<=term_cnt+1.
//  pv=1, term_cnt==COUNT-1 (completion): acc<=0; term_cnt<=0; result candidate is nxt.
//   COUNT=1: every pv is a completion.
//  Output register, evaluated at each edge:
//   - drain: res_valid && res_ready, and no completion -> res_valid<=0.
//   - completion with !res_valid, or with res_valid && res_ready -> res_data<=nxt; res_valid<=1.
//     Back-to-back handoff: res_valid stays 1 with no bubble.
//   - completion with res_valid && !res_ready -> res_data and res_valid hold; new result discarded; ovr<=1.
//     acc is still cleared, so the next vector starts clean.
//  res_data is stable while res_valid && !res_ready.
//  Latency: last op_valid at cycle t -> res_valid first high in cycle t+LAT+1.
//  Throughput: one partial sum per clock, no gaps required.
//  ovr clears only on rst.
//  rst mid-accumulation: partial acc and in-flight vld_dly are lost.
//   psums whose op_valid preceded rst deassertion are ignored.
//  No FSM states beyond the term_cnt phase and res_valid: IDLE == term_cnt 0 && !res_valid.
// CONFIGURATION
//  SAT_ACCUM_EN defined:
//   - nxt is computed with one carry bit.
//   - On carry, nxt clamps to {ACC_W{1'b1}} and stays clamped for the rest of that vector.
//   - Adds output sat (1 bit), registered alongside res_data: set if any clamp occurred in that vector.
//  SAT_ACCUM_EN undefined: wrap modulo 2^ACC_W; no sat port.
// TESTING
//  1. COUNT=4, LAT=2, res_ready=1; psums 10,20,30,40 on pv cycles 2..5
//     -> res_data=100, res_valid high one cycle (cycle 6), term_cnt back to 0.
//  2. Two vectors back-to-back (1..8, then 8 x 5), res_ready=1
//     -> results 36 then 40, res_valid never drops between them when consecutive; ovr=0.
//  3. Hold res_ready=0 across second completion (vectors sum 36, 40)
//     -> res_data stays 36, ovr=1; raise res_ready -> 36 accepted, res_valid=0.
//  4. Assert rst after 3 of 4 psums (10,20,30), then feed 1,2,3,4
//     -> result 10; no residue of 60; ovr=0.
//  5. ACC_W=32, psums 32'hFFFF_FFFF x2 in one vector
//     -> no SAT_ACCUM_EN: 32'hFFFF_FFFE; with SAT_ACCUM_EN: 32'hFFFF_FFFF, sat=1.
//  6. op_valid gaps (pattern 1,0,0,1,1,0,1), COUNT=4, psum=7 each
//     -> single result 28, issued LAT+1 after the 4th op_valid.

Source files
------------

// File: rtl/dot_accum.sv
// Accumulates COUNT partial sums from a fixed-latency multiply-add stage into one dot product.
// Optional feature macro SAT_ACCUM_EN: saturating accumulation with a per-result sat flag.
module dot_accum #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 40,
  parameter int COUNT = 8,
  parameter int LAT   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             op_valid_i,
  input  logic [WIDTH-1:0] psum_i,
  output logic [ACC_W-1:0] res_data_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             ovr_o,
`ifdef SAT_ACCUM_EN
  output logic             sat_o,
`endif
  output logic [15:0]      term_cnt_o
);

  localparam logic [15:0] LAST_TERM = 16'(COUNT - 1);

  // Valid tracks the operands through the multiply-add pipe, one flop per stage.
  logic vld_dly_q [LAT];

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) vld_dly_q[gi] <= 1'b0;
          else       vld_dly_q[gi] <= op_valid_i;
        end
      end else begin : g_tap
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) vld_dly_q[gi] <= 1'b0;
          else       vld_dly_q[gi] <= vld_dly_q[gi-1];
        end
      end
    end
  endgenerate

  logic             pv;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      term_cnt_q, term_cnt_d;
  logic [ACC_W-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             ovr_q, ovr_d;
  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W-1:0] nxt;
  logic             last_term;
  logic             complete;
  logic             clamp;
`ifdef SAT_ACCUM_EN
  logic [ACC_W:0]   sum_w;
  logic             sat_run_q, sat_run_d;
  logic             sat_q, sat_d;
`endif

  assign pv = vld_dly_q[LAT-1];

  always_comb begin
    psum_ext = '0;
    psum_ext[WIDTH-1:0] = psum_i;
`ifdef SAT_ACCUM_EN
    sum_w = {1'b0, acc_q} + {1'b0, psum_ext};
    // Once a vector has clamped it stays pinned at full scale until it completes.
    clamp = sat_run_q | sum_w[ACC_W];
    nxt   = clamp ? '1 : sum_w[ACC_W-1:0];
`else
    clamp = 1'b0;
    nxt   = acc_q + psum_ext;
`endif
    last_term = (term_cnt_q == LAST_TERM);
    complete  = pv && last_term;

    acc_d       = acc_q;
    term_cnt_d  = term_cnt_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    ovr_d       = ovr_q;
`ifdef SAT_ACCUM_EN
    sat_run_d   = sat_run_q;
    sat_d       = sat_q;
`endif

    if (pv) begin
      if (last_term) begin
        acc_d      = '0;
        term_cnt_d = '0;
`ifdef SAT_ACCUM_EN
        sat_run_d  = 1'b0;
`endif
      end else begin
        acc_d      = nxt;
        term_cnt_d = term_cnt_q + 16'd1;
`ifdef SAT_ACCUM_EN
        sat_run_d  = clamp;
`endif
      end
    end

    // A finished vector that finds the output slot occupied is dropped, not stalled.
    if (complete) begin
      if (!res_valid_q || res_ready_i) begin
        res_data_d  = nxt;
        res_valid_d = 1'b1;
`ifdef SAT_ACCUM_EN
        sat_d       = clamp;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      term_cnt_q  <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
`ifdef SAT_ACCUM_EN
      sat_run_q   <= 1'b0;
      sat_q       <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      term_cnt_q  <= term_cnt_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      ovr_q       <= ovr_d;
`ifdef SAT_ACCUM_EN
      sat_run_q   <= sat_run_d;
      sat_q       <= sat_d;
`endif
    end
  end

  assign res_data_o  = res_data_q;
  assign res_valid_o = res_valid_q;
  assign ovr_o       = ovr_q;
  assign term_cnt_o  = term_cnt_q;
`ifdef SAT_ACCUM_EN
  assign sat_o       = sat_q;
`endif

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: directed scenarios plus randomized traffic against a vector-level model.
module tb_dot_accum;
  localparam int WIDTH = 32;
  localparam int ACC_W = 33;
  localparam int COUNT = 4;
  localparam int LAT   = 2;
  localparam longint unsigned MASK = (64'd1 << ACC_W) - 64'd1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             op_valid_i = 1'b0;
  logic [WIDTH-1:0] psum_i = '0;
  logic             res_ready_i = 1'b0;
  logic [ACC_W-1:0] res_data_o;
  logic             res_valid_o;
  logic             ovr_o;
  logic [15:0]      term_cnt_o;
`ifdef SAT_ACCUM_EN
  logic             sat_o;
`endif

  dot_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W), .COUNT(COUNT), .LAT(LAT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .op_valid_i  (op_valid_i),
    .psum_i      (psum_i),
    .res_data_o  (res_data_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .ovr_o       (ovr_o),
`ifdef SAT_ACCUM_EN
    .sat_o       (sat_o),
`endif
    .term_cnt_o  (term_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Model: history of op_valid, list of absorbed terms of the open vector, output slot.
  bit               hist[$];
  longint unsigned  terms[$];
  bit               m_valid;
  longint unsigned  m_data;
  bit               m_ovr;
  bit               m_sat;
  longint unsigned  dlog[$];
  int               xfer_n = 0;

  always @(posedge clk_i) begin
    bit pv, comp, satf;
    longint unsigned total, cand;
    if (!rst_i && res_valid_o && res_ready_i) begin
      dlog.push_back(longint'(res_data_o));
      $display("xfer %0d t=%0t data=%0h", xfer_n, $time, res_data_o);
      xfer_n++;
    end
    if (rst_i) begin
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
      terms.delete();
      m_valid = 0; m_data = 0; m_ovr = 0; m_sat = 0;
    end else begin
      pv = hist.pop_front();
      hist.push_back(op_valid_i);
      comp = 0; cand = 0; satf = 0;
      if (pv) begin
        terms.push_back(longint'(psum_i));
        if (terms.size() == COUNT) begin
          total = 0;
          foreach (terms[i]) total += terms[i];
          terms.delete();
          comp = 1;
`ifdef SAT_ACCUM_EN
          satf = (total > MASK);
          cand = satf ? MASK : total;
`else
          cand = total & MASK;
`endif
        end
      end
      if (comp) begin
        if (!m_valid || res_ready_i) begin
          m_valid = 1; m_data = cand; m_sat = satf;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && res_ready_i) begin
        m_valid = 0;
      end
    end
    #1;
    chk("cyc_valid", res_valid_o, m_valid);
    chk("cyc_data", res_data_o, m_data);
    chk("cyc_ovr", ovr_o, m_ovr);
    chk("cyc_term", term_cnt_o, terms.size());
`ifdef SAT_ACCUM_EN
    chk("cyc_sat", sat_o, m_sat);
`endif
  end

  logic [WIDTH-1:0] spipe[$];

  // psum follows its op_valid by LAT cycles, as the multiply-add stage would deliver it.
  task automatic step(input bit op, input logic [WIDTH-1:0] v, input bit rdy, input bit rst);
    @(negedge clk_i);
    rst_i       = rst;
    op_valid_i  = op;
    res_ready_i = rdy;
    psum_i      = spipe.pop_front();
    spipe.push_back(v);
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, $urandom(), rdy, 1'b0);
  endtask

  initial begin
    bit pat[7];
    logic [WIDTH-1:0] rv;
    for (int i = 0; i < LAT; i++) spipe.push_back('0);
    pat = '{1, 0, 0, 1, 1, 0, 1};

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", res_valid_o, 0);
    chk("rst_term", term_cnt_o, 0);
    chk("rst_ovr", ovr_o, 0);
    chk("rst_data", res_data_o, 0);

    // 10+20+30+40, result one cycle after the last psum
    dlog.delete();
    step(1, 10, 1, 0); step(1, 20, 1, 0); step(1, 30, 1, 0); step(1, 40, 1, 0);
    idle(LAT - 1, 1);
    chk("t1_early", res_valid_o, 0);
    idle(1, 1);
    chk("t1_valid", res_valid_o, 1);
    chk("t1_data", res_data_o, 100);
    chk("t1_term", term_cnt_o, 0);
    idle(1, 1);
    chk("t1_drain", res_valid_o, 0);
    chk("t1_count", dlog.size(), 1);

    // back-to-back vectors 1..4 and 4x5, handoff on the second completion edge
    dlog.delete();
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 5, 0, 0);
    idle(LAT - 1, 0);
    chk("t2_first", res_data_o, 10);
    idle(1, 1);
    chk("t2_handoff_valid", res_valid_o, 1);
    chk("t2_second", res_data_o, 20);
    chk("t2_ovr", ovr_o, 0);
    idle(1, 1);
    chk("t2_drain", res_valid_o, 0);
    chk("t2_count", dlog.size(), 2);

    // full-scale terms overflow the accumulator
    for (int i = 0; i < 4; i++) step(1, 32'hFFFF_FFFF, 1, 0);
    idle(LAT, 1);
`ifdef SAT_ACCUM_EN
    chk("t5_data", res_data_o, 64'h1_FFFF_FFFF);
    chk("t5_sat", sat_o, 1);
`else
    chk("t5_data", res_data_o, 64'h1_FFFF_FFFC);
`endif
    idle(1, 1);

    // gapped op_valid, psum 7 each
    foreach (pat[i]) step(pat[i], 7, 1, 0);
    idle(LAT - 1, 1);
    chk("t6_early", res_valid_o, 0);
    idle(1, 1);
    chk("t6_valid", res_valid_o, 1);
    chk("t6_data", res_data_o, 28);
    idle(1, 1);

    // second completion while the slot is held: dropped, ovr set
    dlog.delete();
    step(1, 5, 0, 0); step(1, 6, 0, 0); step(1, 7, 0, 0); step(1, 18, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 10, 0, 0);
    idle(LAT, 0);
    chk("t3_hold", res_data_o, 36);
    chk("t3_ovr", ovr_o, 1);
    idle(1, 1);
    chk("t3_drain", res_valid_o, 0);
    chk("t3_acc", (dlog.size() > 0) ? dlog[0] : 0, 36);

    // reset mid-vector discards the partial sum
    step(1, 10, 1, 0); step(1, 20, 1, 0); step(1, 30, 1, 0);
    idle(LAT, 1);
    chk("t4_partial", term_cnt_o, 3);
    step(0, 0, 1, 1);
    chk("t4_ovr", ovr_o, 0);
    chk("t4_term", term_cnt_o, 0);
    for (int i = 1; i <= 4; i++) step(1, i, 1, 0);
    idle(LAT, 1);
    chk("t4_valid", res_valid_o, 1);
    chk("t4_data", res_data_o, 10);
    idle(1, 1);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 32'hFFFF_FFFF - $urandom_range(0, 255);
        1:       rv = $urandom_range(0, 15);
        default: rv = $urandom();
      endcase
      step($urandom_range(0, 9) < 7, rv, $urandom_range(0, 9) < 6, $urandom_range(0, 399) == 0);
    end
    idle(LAT + 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
